vga_timing_gen: RTL and testbench

//  Parametrised VGA raster engine. Next generation of the fixed 640x480 display controller in this codebase.

---
 rtl/vga_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: porch/sync timing, pixel-source requests with latency
// compensation, built-in test patterns and frame/line strobes, all aligned at PIX_LAT+1.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIX_LAT  = 2,
   parameter int COLOR_W  = 12
) (
   input  logic               clk_25,
   input  logic               rst_n,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [COLOR_W-1:0] fill_color,
   output logic [9:0]         req_x,
   output logic [9:0]         req_y,
   output logic               req_valid,
   input  logic [COLOR_W-1:0] pix_in,
   output logic [COLOR_W-1:0] vga_colors,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               frame_start,
   output logic               line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW      = COLOR_W / 3;

   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] BAR_W  = 10'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

   typedef struct packed {
      logic       act;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
      logic [1:0] md;
      logic [9:0] x;
      logic [9:0] y;
   } stage_t;

   logic [9:0]         col;
   logic [9:0]         row;
   logic [1:0]         mode_lat;
   logic               at_origin;
   logic               active;
   stage_t             head;
   stage_t             tail;
   logic [2:0]         bar_idx;
   logic               grid_on;
   logic [COLOR_W-1:0] color_nxt;

   assign at_origin = (col == 10'd0) && (row == 10'd0);
   assign active    = (col < H_ACT) && (row < V_ACT);

   assign req_x     = col;
   assign req_y     = row;
   assign req_valid = active && en && rst_n;

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         col      <= '0;
         row      <= '0;
         mode_lat <= 2'b00;
      end else if (en) begin
         if (col == H_MAX) begin
            col <= '0;
            row <= (row == V_MAX) ? 10'd0 : row + 10'd1;
         end else begin
            col <= col + 10'd1;
         end
         if (at_origin) begin
            mode_lat <= mode;
         end
      end
   end

   // Mode travels with the pixel so a frame switch lands exactly on pixel (0,0) at any latency.
   always_comb begin
      head     = '0;
      head.act = active && en;
      head.hs  = (col >= HS_BEG) && (col < HS_END);
      head.vs  = (row >= VS_BEG) && (row < VS_END);
      head.ls  = en && (col == 10'd0);
      head.fs  = en && at_origin;
      head.md  = (en && at_origin) ? mode : mode_lat;
      head.x   = col;
      head.y   = row;
   end

   generate
      if (PIX_LAT == 0) begin : g_no_lat
         assign tail = head;
      end else begin : g_lat
         stage_t dly [PIX_LAT];

         always_ff @(posedge clk_25 or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < PIX_LAT; i++) begin
                  dly[i] <= '0;
               end
            end else begin
               dly[0] <= head;
               for (int i = 1; i < PIX_LAT; i++) begin
                  dly[i] <= dly[i-1];
               end
            end
         end

         assign tail = dly[PIX_LAT-1];
      end
   endgenerate

   always_comb begin
      bar_idx   = 3'(tail.x / BAR_W);
      grid_on   = (tail.x[4:0] == 5'd0) || (tail.y[4:0] == 5'd0) ||
                  (tail.x == H_LAST) || (tail.y == V_LAST);
      color_nxt = '0;
      if (tail.act) begin
         unique case (tail.md)
            2'b00: color_nxt = pix_in;
            2'b01: color_nxt = fill_color;
            2'b10: color_nxt = {{CW{~bar_idx[1]}}, {CW{~bar_idx[2]}}, {CW{~bar_idx[0]}}};
            2'b11: color_nxt = {COLOR_W{grid_on}};
         endcase
      end
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         vga_colors  <= '0;
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         vga_colors  <= color_nxt;
         vga_hs      <= tail.hs ? HS_POL : ~HS_POL;
         vga_vs      <= tail.vs ? VS_POL : ~VS_POL;
         frame_start <= tail.fs;
         line_start  <= tail.ls;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (PIX_LAT 0/2/7, both sync polarities) on a reduced
// raster, compared every cycle with a position-arithmetic reference model.
module tb_vga_timing_gen;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VA = 36, VF = 2, VS = 2, VB = 3;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int NDUT = 3;
   localparam int LAT [NDUT] = '{0, 2, 7};
   localparam bit POL [NDUT] = '{1'b1, 1'b0, 1'b0};

   typedef struct {
      bit          act, hs, vs, ls, fs;
      bit [1:0]    md;
      int          x, y;
      logic [11:0] fill;
   } rec_t;

   logic        clk_25 = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic [11:0] fill_color;
   logic [11:0] pix_in      [NDUT];
   logic [9:0]  req_x       [NDUT];
   logic [9:0]  req_y       [NDUT];
   logic        req_valid   [NDUT];
   logic [11:0] vga_colors  [NDUT];
   logic        vga_hs      [NDUT];
   logic        vga_vs      [NDUT];
   logic        frame_start [NDUT];
   logic        line_start  [NDUT];

   rec_t        hist [$];
   int          mpos, cyc, passed, total;
   bit [1:0]    mlat;
   logic [1:0]  m;
   logic [11:0] src     [NDUT][8];
   logic [11:0] cur_req [NDUT];
   bit          meas;
   int          hs_run, hs_off, last_hs_run, last_hs_off, ls_cyc;
   int          vs_run, last_vs_run, fs_cyc, fs_period;

   always #5 clk_25 = ~clk_25;

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0), .COLOR_W(12)) u_lat0 (
      .clk_25(clk_25), .rst_n(rst_n), .en(en), .mode(mode), .fill_color(fill_color),
      .req_x(req_x[0]), .req_y(req_y[0]), .req_valid(req_valid[0]), .pix_in(pix_in[0]),
      .vga_colors(vga_colors[0]), .vga_hs(vga_hs[0]), .vga_vs(vga_vs[0]),
      .frame_start(frame_start[0]), .line_start(line_start[0]));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .COLOR_W(12)) u_lat2 (
      .clk_25(clk_25), .rst_n(rst_n), .en(en), .mode(mode), .fill_color(fill_color),
      .req_x(req_x[1]), .req_y(req_y[1]), .req_valid(req_valid[1]), .pix_in(pix_in[1]),
      .vga_colors(vga_colors[1]), .vga_hs(vga_hs[1]), .vga_vs(vga_vs[1]),
      .frame_start(frame_start[1]), .line_start(line_start[1]));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(7), .COLOR_W(12)) u_lat7 (
      .clk_25(clk_25), .rst_n(rst_n), .en(en), .mode(mode), .fill_color(fill_color),
      .req_x(req_x[2]), .req_y(req_y[2]), .req_valid(req_valid[2]), .pix_in(pix_in[2]),
      .vga_colors(vga_colors[2]), .vga_hs(vga_hs[2]), .vga_vs(vga_vs[2]),
      .frame_start(frame_start[2]), .line_start(line_start[2]));

   function automatic rec_t blank_rec();
      rec_t r;
      r.act = 0; r.hs = 0; r.vs = 0; r.ls = 0; r.fs = 0; r.md = 2'd0;
      r.x = 0; r.y = 0; r.fill = 12'h000;
      return r;
   endfunction

   function automatic logic [11:0] exp_color(rec_t r, logic [11:0] f);
      logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};
      if (!r.act) return 12'h000;
      case (r.md)
         2'd0:    return 12'((r.y % 16) * 256 + (r.x % 256));
         2'd1:    return f;
         2'd2:    return bars[r.x / (HA / 8)];
         default: return ((r.x % 32 == 0) || (r.y % 32 == 0) || (r.x == HA - 1) || (r.y == VA - 1))
                         ? 12'hFFF : 12'h000;
      endcase
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s dut%0d cyc=%0d got=%h expected=%h", tag, k, cyc, got, exp);
   endtask

   // External pixel source: answers each request LAT cycles later with {y[3:0],x[7:0]}.
   task automatic drive_pix(input bit shift);
      for (int k = 0; k < NDUT; k++) begin
         if (shift) begin
            for (int i = 7; i > 0; i--) src[k][i] = src[k][i-1];
            src[k][0] = cur_req[k];
         end
         cur_req[k] = {req_y[k][3:0], req_x[k][7:0]};
         if (LAT[k] == 0) pix_in[k] = cur_req[k];
         else             pix_in[k] = src[k][LAT[k]-1];
      end
   endtask

   task automatic chk_reset();
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_pins", k, 32'({vga_colors[k], vga_hs[k], vga_vs[k], frame_start[k], line_start[k]}),
             32'({12'h000, ~POL[k], ~POL[k], 1'b0, 1'b0}));
         chk("rst_req", k, 32'({req_x[k], req_y[k], req_valid[k]}), 32'd0);
      end
   endtask

   task automatic release_rst();
      @(negedge clk_25);
      rst_n = 1'b1;
      mpos = 0; mlat = 2'd0; cyc = 0;
      hist.delete();
      drive_pix(1'b0);
   endtask

   task automatic step(input logic en_v, input logic [1:0] mode_v);
      rec_t        r, e;
      int          x, y, idx;
      logic [15:0] exp_o;
      logic [20:0] exp_r;
      @(posedge clk_25);
      x = mpos % HT;
      y = mpos / HT;
      r.act  = en && x < HA && y < VA;
      r.hs   = (x >= HA + HF) && (x < HA + HF + HS);
      r.vs   = (y >= VA + VF) && (y < VA + VF + VS);
      r.ls   = en && x == 0;
      r.fs   = en && mpos == 0;
      if (r.fs) mlat = mode;
      r.md   = mlat;
      r.x    = x;
      r.y    = y;
      r.fill = fill_color;
      hist.push_back(r);
      if (en) mpos = (mpos + 1) % FRAME;
      cyc++;
      #1;
      en   = en_v;
      mode = mode_v;
      drive_pix(1'b1);
      #1;
      x = mpos % HT;
      y = mpos / HT;
      for (int k = 0; k < NDUT; k++) begin
         idx = cyc - 1 - LAT[k];
         e = (idx >= 0) ? hist[idx] : blank_rec();
         exp_o = {exp_color(e, hist[cyc-1].fill), e.hs ? POL[k] : ~POL[k],
                  e.vs ? POL[k] : ~POL[k], e.fs, e.ls};
         chk("pins", k, 32'({vga_colors[k], vga_hs[k], vga_vs[k], frame_start[k], line_start[k]}),
             32'(exp_o));
         exp_r = {10'(x), 10'(y), en && x < HA && y < VA};
         chk("req", k, 32'({req_x[k], req_y[k], req_valid[k]}), 32'(exp_r));
      end
      if (meas) begin
         if (vga_hs[1] == 1'b0) begin
            if (hs_run == 0) hs_off = cyc - ls_cyc;
            hs_run++;
         end else if (hs_run > 0) begin
            last_hs_run = hs_run; last_hs_off = hs_off; hs_run = 0;
         end
         if (vga_vs[1] == 1'b0) vs_run++;
         else if (vs_run > 0) begin last_vs_run = vs_run; vs_run = 0; end
         if (line_start[1]) ls_cyc = cyc;
         if (frame_start[1]) begin
            if (fs_cyc >= 0) fs_period = cyc - fs_cyc;
            fs_cyc = cyc;
         end
      end
   endtask

   initial begin
      passed = 0; total = 0; meas = 0;
      hs_run = 0; hs_off = 0; last_hs_run = 0; last_hs_off = 0; ls_cyc = -1;
      vs_run = 0; last_vs_run = 0; fs_cyc = -1; fs_period = 0;
      for (int k = 0; k < NDUT; k++) begin
         for (int i = 0; i < 8; i++) src[k][i] = 12'h000;
         cur_req[k] = 12'h000;
         pix_in[k]  = 12'h000;
      end
      rst_n = 1'b0; en = 1'b1; mode = 2'b01; fill_color = 12'hABC; m = 2'b00;
      repeat (3) @(posedge clk_25);
      #2 chk_reset();

      // Solid fill with timing measurements on the PIX_LAT=2 instance.
      release_rst();
      meas = 1;
      for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b1, 2'b01);
      meas = 0;
      chk("hs_width", 1, 32'(last_hs_run), 32'(HS));
      chk("hs_offset", 1, 32'(last_hs_off), 32'(HA + HF));
      chk("vs_width", 1, 32'(last_vs_run), 32'(VS * HT));
      chk("fs_period", 1, 32'(fs_period), 32'(FRAME));

      // Mode switch mid-frame: bars only from the next frame.
      fill_color = 12'($urandom);
      for (int i = 0; i < FRAME && mpos != 5 * HT + 10; i++) step(1'b1, 2'b01);
      for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 2'b10);

      // Grid.
      for (int i = 0; i < FRAME + HT; i++) step(1'b1, 2'b11);

      // External pixels with a 50-cycle freeze mid-line.
      for (int i = 0; i < FRAME + 1 && mpos != 0; i++) step(1'b1, 2'b00);
      for (int i = 0; i < FRAME && mpos != 3 * HT + 20; i++) step(1'b1, 2'b00);
      for (int i = 0; i < 50; i++) step(1'b0, 2'b00);
      for (int i = 0; i < FRAME; i++) step(1'b1, 2'b00);

      // Random enable, mode and fill.
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (i % 400 == 0) m = 2'($urandom_range(0, 3));
         if (i % 97 == 0) fill_color = 12'($urandom);
         step(($urandom_range(0, 7) != 0), m);
      end

      // Asynchronous reset mid-line, then a fresh frame.
      for (int i = 0; i < FRAME && mpos != 7 * HT + 30; i++) step(1'b1, 2'b10);
      #1 rst_n = 1'b0;
      #1 chk_reset();
      repeat (2) @(posedge clk_25);
      #2 chk_reset();
      en = 1'b1; mode = 2'($urandom_range(0, 3));
      release_rst();
      for (int i = 0; i < FRAME + 50; i++) step(1'b1, mode);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
